wb_dma_master: RTL and testbench
================================

Name: wb_dma_master

Overview:
- Wishbone classic single-cycle bus master (initiator) that copies a block of 32-bit words from a source address range to a destination address range.
- Drives the same wbs_* slave bus that the user-project address decoder serves, e.g. copying from 0x3800_0000 user memory to 0x3000_03xx FIR/accelerator registers.
- Controlled by a start pulse with source, destination and length; reports busy/done/error.
- Each word is one read cycle followed by one write cycle, each guarded by an ack timeout.

Parameters:
- LEN_W, 10, width of the word-count field (max 1023 words).
- TIMEOUT, 255, max cycles with stb asserted and no ack before abort (1..65535).

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  one-cycle request pulse; accepted only when busy_o=0.
- src_adr_i  in  32  source byte address; bits[1:0] ignored (word aligned).
- dst_adr_i  in  32  destination byte address; bits[1:0] ignored.
- len_i  in  LEN_W  number of words to copy.
- busy_o  out  1  high from acceptance until done/error.
- done_o  out  1  one-cycle pulse on successful completion.
- err_o  out  1  sticky timeout flag; cleared by the next accepted start.
- words_o  out  LEN_W  words fully written so far.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte selects; always 4'hF during an access.
- wbm_adr_o  out  32  address; bits[1:0]=0.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  slave acknowledge.

Behaviour:
- Reset (synchronous, wb_rst_i=1 at a clock edge): every output is 0, state=IDLE. Reset mid-transfer drops cyc/stb on the next edge, with no done pulse and no err.
- FSM states: IDLE, RD, RD_GAP, WR, WR_GAP, DONE.
- IDLE:
  - start_i=1 latches src, dst and len, clears err_o and words_o, sets busy_o.
  - len=0 goes to DONE with no bus cycle. Otherwise goes to RD.
  - start_i while busy_o=1 is ignored.
- RD: cyc=stb=1, we=0, sel=F, adr=src_cur.
  - On the edge where ack_i=1: latch wbm_dat_i into data_q, advance src_cur by 4, go to RD_GAP.
  - ack_i is only sampled while stb=1. The earliest ack is in the first cycle stb is high (zero-wait slave), which is legal.
- RD_GAP: cyc=stb=0 for exactly one cycle, then go to WR.
- WR: cyc=stb=we=1, adr=dst_cur, dat_o=data_q.
  - On ack: advance dst_cur by 4, increment words_o, go to WR_GAP.
- WR_GAP: one idle cycle. If words_o==len go to DONE, else go to RD.
- DONE: done_o=1 for one cycle, busy_o=0 from the next cycle, go to IDLE.
- Per word: exactly 2 bus cycles and 4+ack-wait clocks. Latency with zero-wait acks is 1 (start) + 4·len + 1 (DONE) clocks.
- Timeout:
  - Counter resets on entry to RD/WR and increments each cycle stb=1 with ack_i=0.
  - When it reaches TIMEOUT: drop cyc/stb next edge, set err_o=1, busy_o=0, go to IDLE with no done pulse. words_o keeps its last value.
  - An ack arriving in the same cycle the counter hits TIMEOUT counts as success; ack has priority.
- Address arithmetic is 32-bit modulo: 0xFFFF_FFFC+4 wraps to 0x0000_0000 with no error.
- wbm_adr_o, wbm_dat_o and wbm_we_o are held stable for the whole time stb=1. Outside RD/WR, cyc/stb/we/sel are 0.
- Spurious ack_i while stb=0 is ignored.

Decomposition:
- Shared package wb_dma_pkg holds:
  - state encoding localparams (IDLE..DONE, 3-bit);
  - WB_SEL_ALL = 4'hF;
  - WORD_STRIDE = 32'd4.
- One natural sub-module, wb_ack_timer: cycle counter with clear, enable and expired output, sized by TIMEOUT. The FSM, address counters and data latch stay in the top module.

Test Plan:
- Zero-wait slave model; start src=0x3800_0000, dst=0x3800_0100, len=3, memory at src = 0x11,0x22,0x33.
  - Expect dst words = 0x11,0x22,0x33, done_o pulse at clock 14 after start, words_o=3, err_o=0.
- Slave inserts 2 wait states on every ack; len=2.
  - Expect adr/dat/we stable throughout each stb, a 1-cycle cyc gap between accesses, and correct copy.
- len=0 start.
  - Expect no cyc ever asserted, done_o one cycle after start, busy_o back to 0.
- Slave never acks on the write of word 2, TIMEOUT=8.
  - Expect stb dropped after 8 stalled cycles, err_o=1, no done_o, words_o=1.
  - Then a new start clears err_o.
- src=0xFFFF_FFF8, len=3.
  - Expect read addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Assert wb_rst_i during a WR wait state, and pulse start while busy.
  - Expect cyc/stb=0 the next cycle and all outputs 0.
  - Expect the busy-time start to be ignored, with no restart of src/len.

Source files
------------

// File: rtl/wb_dma_pkg.sv
// wb_dma_pkg: state encoding and bus constants shared by the Wishbone DMA master
package wb_dma_pkg;
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_RD     = 3'd1;
   localparam logic [2:0] ST_RD_GAP = 3'd2;
   localparam logic [2:0] ST_WR     = 3'd3;
   localparam logic [2:0] ST_WR_GAP = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;
   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      RD     = ST_RD,
      RD_GAP = ST_RD_GAP,
      WR     = ST_WR,
      WR_GAP = ST_WR_GAP,
      DONE   = ST_DONE
   } state_t;
   localparam logic [3:0]  WB_SEL_ALL  = 4'hF;
   localparam logic [31:0] WORD_STRIDE = 32'd4;
endpackage

// File: rtl/wb_ack_timer.sv
// wb_ack_timer: counts stalled strobe cycles and flags the TIMEOUT-th one
module wb_ack_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk)
      if (rst || clr) cnt <= '0;
      else if (en) cnt <= cnt + CW'(1);
   // an acked cycle never has en set, so a same-cycle ack wins over expiry
   assign expired = en && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/wb_dma_master.sv
// wb_dma_master: Wishbone classic master copying len words from src to dst, one read then one write per word
module wb_dma_master
   import wb_dma_pkg::*;
#(
   parameter int LEN_W   = 10,
   parameter int TIMEOUT = 255
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             start_i,
   input  logic [31:0]      src_adr_i,
   input  logic [31:0]      dst_adr_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [LEN_W-1:0] words_o,
   output logic             wbm_cyc_o,
   output logic             wbm_stb_o,
   output logic             wbm_we_o,
   output logic [3:0]       wbm_sel_o,
   output logic [31:0]      wbm_adr_o,
   output logic [31:0]      wbm_dat_o,
   input  logic [31:0]      wbm_dat_i,
   input  logic             wbm_ack_i
);
   state_t state, state_nx;
   logic [31:0] src_q, dst_q, data_q;
   logic [LEN_W-1:0] len_q, words_q;
   logic err_q, expired;
   wb_ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk(wb_clk_i),
      .rst(wb_rst_i),
      .clr(!wbm_stb_o),
      .en(wbm_stb_o && !wbm_ack_i),
      .expired(expired)
   );
   always_ff @(posedge wb_clk_i)
      if (wb_rst_i) begin
         state   <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         data_q  <= '0;
         len_q   <= '0;
         words_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start_i) begin
            src_q   <= src_adr_i & ~32'h3;
            dst_q   <= dst_adr_i & ~32'h3;
            len_q   <= len_i;
            words_q <= '0;
            err_q   <= 1'b0;
         end
         if (state == RD && wbm_ack_i) begin
            data_q <= wbm_dat_i;
            src_q  <= src_q + WORD_STRIDE;
         end
         if (state == WR && wbm_ack_i) begin
            dst_q   <= dst_q + WORD_STRIDE;
            words_q <= words_q + LEN_W'(1);
         end
         if (expired) err_q <= 1'b1;
      end
   always_comb begin
      state_nx  = state;
      wbm_cyc_o = 1'b0;
      wbm_stb_o = 1'b0;
      wbm_we_o  = 1'b0;
      wbm_sel_o = '0;
      wbm_adr_o = '0;
      wbm_dat_o = '0;
      case (state)
         IDLE:   if (start_i) state_nx = (len_i == '0) ? DONE : RD;
         RD: begin
            wbm_cyc_o = 1'b1;
            wbm_stb_o = 1'b1;
            wbm_sel_o = WB_SEL_ALL;
            wbm_adr_o = src_q;
            state_nx  = wbm_ack_i ? RD_GAP : (expired ? IDLE : RD);
         end
         RD_GAP: state_nx = WR;
         WR: begin
            wbm_cyc_o = 1'b1;
            wbm_stb_o = 1'b1;
            wbm_we_o  = 1'b1;
            wbm_sel_o = WB_SEL_ALL;
            wbm_adr_o = dst_q;
            wbm_dat_o = data_q;
            state_nx  = wbm_ack_i ? WR_GAP : (expired ? IDLE : WR);
         end
         WR_GAP: state_nx = (words_q == len_q) ? DONE : RD;
         DONE:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   assign busy_o  = state != IDLE;
   assign done_o  = state == DONE;
   assign err_o   = err_q;
   assign words_o = words_q;
endmodule

// File: tb/tb_wb_dma_master.sv
// tb_wb_dma_master: directed vector table plus hand sequences for timeout and reset
module tb_wb_dma_master;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [31:0] src = '0, dst = '0;
   logic [9:0] len = '0;
   logic busy, done, err, cyc, stb, we, ack;
   logic [9:0] words;
   logic [3:0] sel;
   logic [31:0] adr, dat_o, dat_i;
   wb_dma_master #(.LEN_W(10), .TIMEOUT(8)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .src_adr_i(src), .dst_adr_i(dst),
      .len_i(len), .busy_o(busy), .done_o(done), .err_o(err), .words_o(words),
      .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
      .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack)
   );
   always #5 clk = ~clk;
   int tests = 0, fails = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   // slave: 16-word memory folded from address bits 8 and 4:2
   function automatic logic [3:0] idx(input logic [31:0] a);
      return {a[8], a[4:2]};
   endfunction
   logic [31:0] mem [16];
   int wait_n = 0, wcnt = 0;
   logic spur = 1'b0;
   logic [31:0] stall_adr = 32'h1;
   assign ack = (stb && wcnt == wait_n && !(we && adr == stall_adr)) || (spur && !stb);
   assign dat_i = mem[idx(adr)];
   always @(posedge clk) begin
      if (!stb || ack) wcnt <= 0;
      else wcnt <= wcnt + 1;
      if (stb && we && ack) mem[idx(adr)] = dat_o;
   end
   // bus monitor
   logic [31:0] rd_q[$];
   int stab_err = 0, gap_err = 0, stall_cnt = 0;
   bit cyc_seen = 0, prev_wait = 0, prev_ack = 0;
   logic [31:0] p_adr, p_dat;
   logic p_we;
   always @(negedge clk) begin
      if (stb) begin
         if (prev_wait && (adr !== p_adr || we !== p_we || (we && dat_o !== p_dat))) stab_err++;
         if (!cyc || sel !== 4'hF || adr[1:0] != 2'b00) stab_err++;
         if (!ack) stall_cnt++;
         if (ack && !we) rd_q.push_back(adr);
         p_adr = adr; p_we = we; p_dat = dat_o;
         prev_wait = !ack;
      end else prev_wait = 0;
      if (prev_ack && cyc) gap_err++;
      prev_ack = stb && ack;
      if (cyc) cyc_seen = 1;
   end
   typedef struct {
      logic [31:0] src, dst;
      logic [9:0]  len;
      int          wait_n;
      logic        spur;
      int          inj;
      int          exp_cyc;
      logic [9:0]  exp_words;
   } vec_t;
   vec_t vecs[5];
   task automatic clear_mon();
      rd_q.delete();
      stab_err = 0; gap_err = 0; stall_cnt = 0; cyc_seen = 0;
   endtask
   task automatic run(input vec_t v);
      int n, dcyc;
      for (int k = 0; k < 16; k++) mem[k] = '0;
      for (int k = 0; k < int'(v.len); k++) mem[idx(v.src + 32'(4 * k))] = 32'h11 * (k + 1);
      clear_mon();
      wait_n = v.wait_n; spur = v.spur;
      @(negedge clk); start = 1; src = v.src; dst = v.dst; len = v.len;
      @(negedge clk); start = 0; n = 2;
      chk("busy_after_start", busy, 1);
      dcyc = 0;
      while (dcyc == 0 && n < 400) begin
         if (done) dcyc = n;
         else begin
            if (n == v.inj) begin start = 1; src = 32'h3800_0020; len = 10'd5; end
            else start = 0;
            @(negedge clk); n++;
         end
      end
      start = 0;
      chk("done_cycle", dcyc, v.exp_cyc);
      @(negedge clk);
      chk("busy_cleared", busy, 0);
      chk("done_single", done, 0);
      chk("err", err, 0);
      chk("words", words, v.exp_words);
      chk("rd_count", rd_q.size(), v.len);
      for (int k = 0; k < rd_q.size(); k++) chk("rd_adr", rd_q[k], v.src + 32'(4 * k));
      for (int k = 0; k < int'(v.len); k++) chk("dst_data", mem[idx(v.dst + 32'(4 * k))], 32'h11 * (k + 1));
      chk("stable", stab_err, 0);
      chk("gap", gap_err, 0);
      chk("wait_states", stall_cnt, 2 * v.wait_n * int'(v.len));
      chk("cyc_seen", cyc_seen, v.len != 0);
      spur = 0;
   endtask
   initial begin
      int n, dcyc;
      bit dseen;
      vecs[0] = '{32'h3800_0000, 32'h3800_0100, 10'd3, 0, 1'b0, 0, 14, 10'd3};
      vecs[1] = '{32'h3800_0000, 32'h3800_0100, 10'd2, 2, 1'b1, 0, 18, 10'd2};
      vecs[2] = '{32'h3800_0000, 32'h3800_0100, 10'd0, 0, 1'b0, 0, 2, 10'd0};
      vecs[3] = '{32'hFFFF_FFF8, 32'h3800_0140, 10'd3, 0, 1'b0, 0, 14, 10'd3};
      vecs[4] = '{32'h3800_0000, 32'h3800_0100, 10'd2, 0, 1'b0, 4, 10, 10'd2};
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
      chk("rst_words", words, 0); chk("rst_cyc", cyc, 0); chk("rst_stb", stb, 0);
      chk("rst_adr", adr, 0); chk("rst_dat", dat_o, 0); chk("rst_sel", sel, 0);
      rst = 0;
      for (int i = 0; i < 5; i++) run(vecs[i]);
      // expected read addresses across the 32-bit wrap, spelled out
      clear_mon();
      @(negedge clk); start = 1; src = 32'hFFFF_FFF8; dst = 32'h3800_0140; len = 10'd3;
      @(negedge clk); start = 0;
      repeat (14) @(negedge clk);
      chk("wrap_cnt", rd_q.size(), 3);
      if (rd_q.size() == 3) begin
         chk("wrap0", rd_q[0], 32'hFFFF_FFF8);
         chk("wrap1", rd_q[1], 32'hFFFF_FFFC);
         chk("wrap2", rd_q[2], 32'h0000_0000);
      end
      // write of word 2 never acked: 8 stalled strobes then abort
      clear_mon();
      stall_adr = 32'h3800_0104;
      @(negedge clk); start = 1; src = 32'h3800_0000; dst = 32'h3800_0100; len = 10'd3;
      @(negedge clk); start = 0; n = 2; dseen = 0;
      while (busy && n < 200) begin
         if (done) dseen = 1;
         @(negedge clk); n++;
      end
      chk("to_idle_cycle", n, 16);
      chk("to_stall_cnt", stall_cnt, 8);
      chk("to_err", err, 1);
      chk("to_words", words, 1);
      chk("to_no_done", dseen, 0);
      chk("to_cyc", cyc, 0);
      stall_adr = 32'h1;
      @(negedge clk); start = 1; len = 10'd1;
      @(negedge clk); start = 0;
      chk("restart_err_clr", err, 0);
      n = 2; dcyc = 0;
      while (dcyc == 0 && n < 100) begin
         if (done) dcyc = n;
         else begin @(negedge clk); n++; end
      end
      chk("restart_done", dcyc, 6);
      chk("restart_words", words, 1);
      // reset during a write wait state
      wait_n = 3;
      clear_mon();
      @(negedge clk); start = 1; src = 32'h3800_0000; dst = 32'h3800_0100; len = 10'd3;
      @(negedge clk); start = 0; n = 0;
      while (!(stb && we) && n < 100) begin @(negedge clk); n++; end
      chk("rst_reached_wr", stb && we, 1);
      rst = 1;
      @(negedge clk);
      chk("mid_rst_cyc", cyc, 0); chk("mid_rst_stb", stb, 0); chk("mid_rst_busy", busy, 0);
      chk("mid_rst_err", err, 0); chk("mid_rst_done", done, 0); chk("mid_rst_words", words, 0);
      chk("mid_rst_adr", adr, 0); chk("mid_rst_we", we, 0);
      rst = 0; cyc_seen = 0; dseen = 0;
      repeat (6) begin @(negedge clk); if (done) dseen = 1; end
      chk("post_rst_no_done", dseen, 0);
      chk("post_rst_no_cyc", cyc_seen, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
